// File: rtl/evb_master_pkg.sv
// Shared constants, types and helpers for the EV bus master.
//   FUNC_*      : EV micro-op function codes (func3)
//   TAG_*       : access size tags (tag2)
//   EVB_MASK_*  : half-word write masks driven on the EVB command bus
//   EV_REG_*    : internal register indices (addr[3:0])
package evb_master_pkg;

    localparam logic [2:0]  FUNC_EV     = 3'b000;   // read old value and write
    localparam logic [2:0]  FUNC_DW     = 3'b001;   // read-only, mask forced to 00
    localparam logic [2:0]  FUNC_DR     = 3'b010;   // access without write-back

    localparam logic [1:0]  TAG_W       = 2'b00;
    localparam logic [1:0]  TAG_H       = 2'b01;
    localparam logic [1:0]  TAG_L       = 2'b10;

    localparam logic [1:0]  EVB_MASK_NONE = 2'b00;
    localparam logic [1:0]  EVB_MASK_W    = 2'b11;
    localparam logic [1:0]  EVB_MASK_H    = 2'b10;
    localparam logic [1:0]  EVB_MASK_L    = 2'b01;

    localparam logic [3:0]  EV_REG_MVEC = 4'd0;
    localparam logic [3:0]  EV_REG_MEPC = 4'd1;
    localparam logic [3:0]  EV_REG_STAT = 4'd2;
    localparam logic [3:0]  EV_REG_TMO  = 4'd3;

    localparam logic [31:0] EV_ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_INT,
        ST_WAIT
    } ev_state_e;

    // Micro-op fields captured when en is accepted.
    typedef struct packed {
        logic [2:0]  func;
        logic [1:0]  tag;
        logic        sel;
        logic [31:0] data;
    } ev_op_t;

    // Write mask for an op: read-only ops never write.
    function automatic logic [1:0] ev_mask(input logic [2:0] func, input logic [1:0] tag);
        logic [1:0] m;
        m = EVB_MASK_NONE;
        if (func != FUNC_DW) begin
            case (tag)
                TAG_W:   m = EVB_MASK_W;
                TAG_H:   m = EVB_MASK_H;
                TAG_L:   m = EVB_MASK_L;
                default: m = EVB_MASK_NONE;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/evb_master_chan_mux.sv
// Channel decode and completion select for the EVB master.
//   ch_i          : selected channel index
//   finish_i      : per-channel completion strobes
//   rd_data_i     : per-channel read data, channel i at [32i +: 32]
//   onehot_c_o    : one-hot decode of ch_i
//   fin_c_o       : completion of the selected channel only
//   rd_data_c_o   : read data of the selected channel
module evb_master_chan_mux #(
    parameter int unsigned NCH = 2,
    parameter int unsigned CWS = 1
) (
    input  logic [CWS-1:0]    ch_i,
    input  logic [NCH-1:0]    finish_i,
    input  logic [NCH*32-1:0] rd_data_i,
    output logic [NCH-1:0]    onehot_c_o,
    output logic              fin_c_o,
    output logic [31:0]       rd_data_c_o
);

    // AND-OR select keeps finish strobes of other channels out of the result.
    always_comb begin
        onehot_c_o  = '0;
        rd_data_c_o = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            onehot_c_o[i] = (ch_i == CWS'(i));
            if (onehot_c_o[i]) begin
                rd_data_c_o = rd_data_c_o | rd_data_i[32*i +: 32];
            end
        end
        fin_c_o = |(finish_i & onehot_c_o);
    end

endmodule

// File: rtl/evb_master.sv
// EV load/store unit: runs EV micro-ops against NCH external EVB channels or
// a small internal register file, holding the pipeline for each access.
//   clk, rst                 : clock, async active-high reset
//   en, func3, tag2, ev_*    : micro-op from decode (accepted only while idle)
//   mepc / mvec              : exception PC in (reg1) / vector base out (reg0)
//   stall                    : pipeline hold for the duration of an access
//   ev_data_wr/_wr_f/_out    : write-back strobe, full-word flag, data
//   ev_err                   : one-cycle pulse on access timeout
//   evb_cmd_*                : shared EVB command bus, per-channel request/finish
module evb_master
    import evb_master_pkg::*;
#(
    parameter int unsigned AW    = 16,
    parameter int unsigned NCH   = 2,
    parameter int unsigned NREG  = 4,
    parameter int unsigned TMO_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        func3,
    input  logic [1:0]        tag2,
    input  logic [AW-1:0]     ev_addr,
    input  logic              ev_data_in_sel,
    input  logic [31:0]       ev_data,
    input  logic [1:0]        ev_data_fwd,
    input  logic [31:0]       ev_data_fwd_data,
    input  logic [15:0]       mepc,
    output logic [15:0]       mvec,
    output logic              stall,
    output logic              ev_data_wr,
    output logic              ev_data_wr_f,
    output logic [31:0]       ev_data_out,
    output logic              ev_err,
    output logic [NCH-1:0]    evb_cmd_request,
    output logic [AW-1:0]     evb_cmd_addr,
    output logic [1:0]        evb_cmd_wr_mask,
    output logic [31:0]       evb_cmd_wr_data,
    input  logic [NCH-1:0]    evb_cmd_finish,
    input  logic [NCH*32-1:0] evb_cmd_rd_data
);

    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 0;
    localparam int unsigned CWS = (CW > 0) ? CW : 1;
    localparam logic [4:0]  NREG_L = 5'(NREG);

    ev_state_e          state_q;
    ev_op_t             op_q;
    logic [AW-1:0]      addr_q;
    logic [31:0]        wdata_q;
    logic [1:0]         wmask_q;
    logic [TMO_W-1:0]   cnt_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               stat_err_q;
    logic [CWS-1:0]     stat_ch_q;
    logic [31:0]        scr_q [16];

    logic [CWS-1:0]     ch_c;
    logic [NCH-1:0]     onehot_c;
    logic               fin_c;
    logic [31:0]        rd_data_c;
    logic               int_c;
    logic [3:0]         idx_c;
    logic               idx_ok_c;
    logic [31:0]        merged_c;
    logic [31:0]        send_c;
    logic [31:0]        rd_val_c;
    logic               expire_c;
    logic               done_c;

    // Channel index comes from the top address bits; a single channel is always 0.
    generate
        if (CW > 0) begin : g_ch
            assign ch_c = addr_q[AW-1 -: CWS];
        end else begin : g_ch0
            assign ch_c = '0;
        end
    endgenerate

    evb_master_chan_mux #(
        .NCH (NCH),
        .CWS (CWS)
    ) u_chan_mux (
        .ch_i        (ch_c),
        .finish_i    (evb_cmd_finish),
        .rd_data_i   (evb_cmd_rd_data),
        .onehot_c_o  (onehot_c),
        .fin_c_o     (fin_c),
        .rd_data_c_o (rd_data_c)
    );

    assign int_c    = (addr_q[AW-1:4] == '0);
    assign idx_c    = addr_q[3:0];
    assign idx_ok_c = ({1'b0, idx_c} < NREG_L);
    assign expire_c = (cnt_q <= TMO_W'(1));

    // Forwarding is applied per half-word using the values present at launch.
    assign merged_c = {ev_data_fwd[1] ? ev_data_fwd_data[31:16] : op_q.data[31:16],
                       ev_data_fwd[0] ? ev_data_fwd_data[15:0]  : op_q.data[15:0]};
    assign send_c   = (op_q.tag == TAG_W) ? merged_c
                    : (op_q.sel ? {16'h0, merged_c[31:16]} : {16'h0, merged_c[15:0]});

    // Access completes after the single INT cycle, or on finish / expiry in WAIT.
    assign done_c = (state_q == ST_INT) || ((state_q == ST_WAIT) && (fin_c || expire_c));

    // Internal register read (pre-write value).
    always_comb begin
        rd_val_c = '0;
        if (idx_ok_c) begin
            case (idx_c)
                EV_REG_MVEC: rd_val_c = {16'h0, mvec};
                EV_REG_MEPC: rd_val_c = {16'h0, mepc};
                EV_REG_STAT: rd_val_c = 32'({stat_ch_q, stat_err_q});
                EV_REG_TMO:  rd_val_c = 32'(tmo_q);
                default:     rd_val_c = scr_q[idx_c];
            endcase
        end
    end

    // Access sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            op_q            <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            cnt_q           <= '0;
            tmo_q           <= '1;
            stat_err_q      <= 1'b0;
            stat_ch_q       <= '0;
            for (int i = 0; i < 16; i++) scr_q[i] <= '0;
            mvec            <= '0;
            stall           <= 1'b0;
            ev_data_wr      <= 1'b0;
            ev_data_wr_f    <= 1'b0;
            ev_data_out     <= '0;
            ev_err          <= 1'b0;
            evb_cmd_request <= '0;
            evb_cmd_addr    <= '0;
            evb_cmd_wr_mask <= '0;
            evb_cmd_wr_data <= '0;
        end else begin
            ev_data_wr   <= 1'b0;
            ev_data_wr_f <= 1'b0;
            ev_err       <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        op_q    <= '{func: func3, tag: tag2, sel: ev_data_in_sel, data: ev_data};
                        addr_q  <= ev_addr;
                        stall   <= 1'b1;
                        state_q <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wdata_q <= send_c;
                    wmask_q <= ev_mask(op_q.func, op_q.tag);
                    if (int_c) begin
                        state_q <= ST_INT;
                    end else begin
                        evb_cmd_request <= onehot_c;
                        evb_cmd_addr    <= addr_q;
                        evb_cmd_wr_mask <= ev_mask(op_q.func, op_q.tag);
                        evb_cmd_wr_data <= send_c;
                        cnt_q           <= tmo_q;
                        state_q         <= ST_WAIT;
                    end
                end
                ST_INT: begin
                    // Read-only and out-of-range registers silently drop writes.
                    if (idx_ok_c) begin
                        case (idx_c)
                            EV_REG_MVEC: if (wmask_q[0]) mvec <= wdata_q[15:0];
                            EV_REG_MEPC: begin end
                            EV_REG_STAT: begin
                                stat_err_q <= 1'b0;
                                stat_ch_q  <= '0;
                            end
                            EV_REG_TMO:  if (wmask_q[0]) tmo_q <= wdata_q[TMO_W-1:0];
                            default: begin
                                if (wmask_q[1]) scr_q[idx_c][31:16] <= wdata_q[31:16];
                                if (wmask_q[0]) scr_q[idx_c][15:0]  <= wdata_q[15:0];
                            end
                        endcase
                    end
                    ev_data_out <= (op_q.tag == TAG_H) ? '0 : rd_val_c;
                end
                ST_WAIT: begin
                    // A finish in the expiry cycle takes priority over the timeout.
                    if (fin_c) begin
                        ev_data_out <= rd_data_c;
                    end else if (expire_c) begin
                        ev_data_out <= EV_ERR_DATA;
                        ev_err      <= 1'b1;
                        stat_err_q  <= 1'b1;
                        stat_ch_q   <= ch_c;
                    end else begin
                        cnt_q <= cnt_q - TMO_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (done_c) begin
                state_q         <= ST_IDLE;
                stall           <= 1'b0;
                ev_data_wr      <= (op_q.func != FUNC_DR);
                ev_data_wr_f    <= (op_q.func != FUNC_DR) && (op_q.tag == TAG_W);
                evb_cmd_request <= '0;
                evb_cmd_addr    <= '0;
                evb_cmd_wr_mask <= '0;
                evb_cmd_wr_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_evb_master.sv
// Scoreboard bench for evb_master: expected write-backs are queued when an op
// is issued and compared when stall falls; bus-side checks are made inline.
module tb_evb_master;
    import evb_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  func3;
    logic [1:0]  tag2;
    logic [15:0] ev_addr;
    logic        ev_data_in_sel;
    logic [31:0] ev_data;
    logic [1:0]  ev_data_fwd;
    logic [31:0] ev_data_fwd_data;
    logic [15:0] mepc;
    logic [15:0] mvec;
    logic        stall;
    logic        ev_data_wr;
    logic        ev_data_wr_f;
    logic [31:0] ev_data_out;
    logic        ev_err;
    logic [1:0]  evb_cmd_request;
    logic [15:0] evb_cmd_addr;
    logic [1:0]  evb_cmd_wr_mask;
    logic [31:0] evb_cmd_wr_data;
    logic [1:0]  evb_cmd_finish;
    logic [63:0] evb_cmd_rd_data;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic        wr;
        logic        wr_f;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   last_en_cyc = 0;
    logic prev_stall = 1'b0;

    evb_master #(.AW(16), .NCH(2), .NREG(4), .TMO_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .func3            (func3),
        .tag2             (tag2),
        .ev_addr          (ev_addr),
        .ev_data_in_sel   (ev_data_in_sel),
        .ev_data          (ev_data),
        .ev_data_fwd      (ev_data_fwd),
        .ev_data_fwd_data (ev_data_fwd_data),
        .mepc             (mepc),
        .mvec             (mvec),
        .stall            (stall),
        .ev_data_wr       (ev_data_wr),
        .ev_data_wr_f     (ev_data_wr_f),
        .ev_data_out      (ev_data_out),
        .ev_err           (ev_err),
        .evb_cmd_request  (evb_cmd_request),
        .evb_cmd_addr     (evb_cmd_addr),
        .evb_cmd_wr_mask  (evb_cmd_wr_mask),
        .evb_cmd_wr_data  (evb_cmd_wr_data),
        .evb_cmd_finish   (evb_cmd_finish),
        .evb_cmd_rd_data  (evb_cmd_rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_wb(input logic [31:0] d, input logic cd, input logic wr,
                             input logic wrf, input logic er, input int lat);
        exp_t e;
        e.data = d; e.chk_data = cd; e.wr = wr; e.wr_f = wrf; e.err = er; e.lat = lat;
        sb_q.push_back(e);
    endtask

    // Write-back monitor: pops one expectation per completed access.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && !stall) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    if (e.chk_data) check("wb_data", ev_data_out, e.data);
                    check("wb_wr", 32'(ev_data_wr), 32'(e.wr));
                    check("wb_wr_f", 32'(ev_data_wr_f), 32'(e.wr_f));
                    check("wb_err", 32'(ev_err), 32'(e.err));
                    if (e.lat != 0) check("wb_lat", 32'(cyc - last_en_cyc + 1), 32'(e.lat));
                end
            end else if (stall) begin
                check("wr_in_access", 32'(ev_data_wr), 32'd0);
                check("err_in_access", 32'(ev_err), 32'd0);
            end
            prev_stall <= stall;
        end
    end

    task automatic issue(input logic [2:0] f, input logic [1:0] t, input logic [15:0] a,
                         input logic sel, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; func3 = f; tag2 = t; ev_addr = a; ev_data_in_sel = sel; ev_data = d;
        last_en_cyc = cyc + 1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (stall && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("done_bound", 32'(stall), 32'd0);
    endtask

    task automatic wait_req();
        int k = 0;
        while (evb_cmd_request == 2'b00 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("req_seen", 32'(evb_cmd_request != 2'b00), 32'd1);
    endtask

    // Completes channel ch 'dly' cycles after the request is first seen.
    task automatic respond(input int ch, input int dly, input logic [31:0] d);
        repeat (dly - 1) @(negedge clk);
        evb_cmd_finish[ch] = 1'b1;
        evb_cmd_rd_data[32*ch +: 32] = d;
        @(negedge clk);
        evb_cmd_finish = '0;
    endtask

    task automatic int_op(input logic [2:0] f, input logic [1:0] t, input logic [15:0] a,
                          input logic [31:0] d, input logic [31:0] exp_d);
        expect_wb(exp_d, 1'b1, f != FUNC_DR, (f != FUNC_DR) && (t == TAG_W), 1'b0, 3);
        issue(f, t, a, 1'b0, d);
        wait_done();
    endtask

    initial begin
        int k;
        rst = 1'b1; en = 1'b0; func3 = '0; tag2 = '0; ev_addr = '0; ev_data_in_sel = 1'b0;
        ev_data = '0; ev_data_fwd = '0; ev_data_fwd_data = '0; mepc = 16'h1357;
        evb_cmd_finish = '0; evb_cmd_rd_data = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_wr", 32'({ev_data_wr, ev_data_wr_f, ev_err}), 32'd0);
        check("rst_out", ev_data_out, 32'd0);
        check("rst_req", 32'({evb_cmd_request, evb_cmd_wr_mask}), 32'd0);
        check("rst_addr_data", evb_cmd_wr_data | 32'(evb_cmd_addr), 32'd0);
        check("rst_mvec", 32'(mvec), 32'd0);
        rst = 1'b0;

        // Internal register file.
        int_op(FUNC_EV, TAG_W, 16'h0000, 32'h1234ABCD, 32'h0);
        check("mvec_w", 32'(mvec), 32'h0000ABCD);
        int_op(FUNC_DW, TAG_L, 16'h0000, 32'h0, 32'h0000ABCD);
        int_op(FUNC_DW, TAG_W, 16'h0001, 32'h0, 32'h00001357);
        int_op(FUNC_DW, TAG_H, 16'h0000, 32'h0, 32'h0);
        int_op(FUNC_EV, TAG_W, 16'h0001, 32'hFFFFFFFF, 32'h00001357);
        int_op(FUNC_DW, TAG_W, 16'h0001, 32'h0, 32'h00001357);
        int_op(FUNC_EV, TAG_W, 16'h0005, 32'hFFFFFFFF, 32'h0);
        int_op(FUNC_DW, TAG_W, 16'h0005, 32'h0, 32'h0);
        check("mvec_hold", 32'(mvec), 32'h0000ABCD);

        // External H read on ch1, finish on ch0 must be ignored.
        expect_wb(32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        issue(FUNC_DW, TAG_H, 16'h8010, 1'b1, 32'h0);
        wait_req();
        check("ext_req", 32'(evb_cmd_request), 32'h2);
        check("ext_addr", 32'(evb_cmd_addr), 32'h8010);
        check("ext_mask_dw", 32'(evb_cmd_wr_mask), 32'(EVB_MASK_NONE));
        for (int i = 1; i < 5; i++) begin
            evb_cmd_finish[0] = (i == 1);
            evb_cmd_rd_data[31:0] = 32'hDEAD0000;
            @(negedge clk);
            check("ext_req_held", 32'(evb_cmd_request), 32'h2);
            check("ext_stall_held", 32'(stall), 32'd1);
        end
        evb_cmd_finish = '0;
        respond(1, 1, 32'hCAFEF00D);
        check("ext_stall_drop", 32'(stall), 32'd0);
        check("ext_req_clear", 32'({evb_cmd_request, evb_cmd_addr}), 32'd0);

        // Timeout: reg3 = 4, ch1 never answers.
        int_op(FUNC_EV, TAG_W, 16'h0003, 32'h4, 32'h000000FF);
        expect_wb(32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        issue(FUNC_EV, TAG_L, 16'h8100, 1'b0, 32'h0);
        wait_req();
        k = 0;
        while (stall && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("tmo_cycles", 32'(k), 32'd4);
        @(negedge clk);
        check("err_pulse_end", 32'(ev_err), 32'd0);
        int_op(FUNC_DW, TAG_W, 16'h0002, 32'h0, 32'h00000003);
        int_op(FUNC_DW, TAG_W, 16'h0002, 32'h0, 32'h0);

        // Finish in the expiry cycle wins.
        expect_wb(32'h600DD00D, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        issue(FUNC_DW, TAG_W, 16'h0040, 1'b0, 32'h0);
        wait_req();
        respond(0, 4, 32'h600DD00D);
        check("coinc_stall", 32'(stall), 32'd0);
        int_op(FUNC_DW, TAG_W, 16'h0002, 32'h0, 32'h0);

        // Low-half forwarding on an L store, then the same with no write-back.
        ev_data_fwd = 2'b01; ev_data_fwd_data = 32'hAAAA5555;
        expect_wb(32'h0BADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        issue(FUNC_EV, TAG_L, 16'h0020, 1'b0, 32'h11112222);
        wait_req();
        check("fwd_data", evb_cmd_wr_data, 32'h00005555);
        check("fwd_mask", 32'(evb_cmd_wr_mask), 32'(EVB_MASK_L));
        check("fwd_req", 32'(evb_cmd_request), 32'h1);
        ev_data_fwd = 2'b00;
        respond(0, 2, 32'h0BADBEEF);
        expect_wb(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        issue(FUNC_DR, TAG_W, 16'h0020, 1'b0, 32'h11112222);
        wait_req();
        check("dr_data", evb_cmd_wr_data, 32'h11112222);
        respond(0, 1, 32'h12345678);
        check("dr_stall", 32'(stall), 32'd0);

        // Reset in the middle of a WAIT.
        issue(FUNC_EV, TAG_W, 16'h8004, 1'b0, 32'h55AA55AA);
        wait_req();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_req", 32'(evb_cmd_request), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_wb", 32'({ev_data_wr, ev_err}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mid_mvec", 32'(mvec), 32'd0);
        int_op(FUNC_DW, TAG_W, 16'h0003, 32'h0, 32'h000000FF);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
